// File: rtl/vend_pkg.sv
// vend_pkg: controller states, coin codes, coin values and the per-cycle coin-sum helper.
// Latency: none, declarations only.
// Backpressure: not applicable.
package vend_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DISPENSE = 2'd1,
      ST_CHANGE   = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      COIN_NONE    = 2'd0,
      COIN_NICKEL  = 2'd1,
      COIN_DIME    = 2'd2,
      COIN_QUARTER = 2'd3
   } coin_e;

   localparam logic [8:0] VAL_NICKEL  = 9'd5;
   localparam logic [8:0] VAL_DIME    = 9'd10;
   localparam logic [8:0] VAL_QUARTER = 9'd25;

   // Value of all coins presented in one cycle (0..40), kept at 9 bits so the
   // ceiling comparison against credit cannot overflow.
   function automatic logic [8:0] coin_sum(input logic n, input logic d, input logic q);
      logic [8:0] s;
      s = 9'd0;
      if (n) s = s + VAL_NICKEL;
      if (d) s = s + VAL_DIME;
      if (q) s = s + VAL_QUARTER;
      return s;
   endfunction

endpackage

// File: rtl/vend_change_pick.sv
// vend_change_pick: greedy choice of the next change coin for a given credit.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller holds credit stable while a coin is pending.
module vend_change_pick
   import vend_pkg::*;
(
   input  logic [7:0] credit,
   output logic [1:0] coin_code,
   output logic [7:0] coin_value
);

   // Largest coin not exceeding the credit; credit is always a multiple of 5,
   // so a nickel is the floor whenever change is still owed.
   always_comb begin
      coin_code  = COIN_NICKEL;
      coin_value = 8'(VAL_NICKEL);
      if (credit >= 8'(VAL_QUARTER)) begin
         coin_code  = COIN_QUARTER;
         coin_value = 8'(VAL_QUARTER);
      end else if (credit >= 8'(VAL_DIME)) begin
         coin_code  = COIN_DIME;
         coin_value = 8'(VAL_DIME);
      end
   end

endmodule

// File: rtl/vend_ctrl.sv
// vend_ctrl: coin-accepting vending controller with dispense handshake and greedy change return.
// Latency: coins/requests act on the next posedge; dispense/ret_valid rise one cycle after the request.
// Backpressure: dispense holds until dispense_ack (or timeout); ret_valid/ret_coin hold while ret_ready is low.
module vend_ctrl
   import vend_pkg::*;
#(
   parameter int unsigned PRICE       = 100,
   parameter int unsigned MAX_CREDIT  = 200,
   parameter int unsigned ACK_TIMEOUT = 1000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       nickel,
   input  logic       dime,
   input  logic       quarter,
   input  logic       vend_req,
   input  logic       cancel,
   output logic       dispense,
   input  logic       dispense_ack,
   output logic       ret_valid,
   output logic [1:0] ret_coin,
   input  logic       ret_ready,
   output logic [7:0] credit,
   output logic       coin_reject,
   output logic       fault,
   output logic       busy
);

   localparam logic [9:0]  PRICE_W  = 10'(PRICE);
   localparam logic [9:0]  MAX_W    = 10'(MAX_CREDIT);
   localparam logic [15:0] TMO_LAST = 16'(ACK_TIMEOUT - 1);

   state_e      state_q, state_d;
   logic [7:0]  credit_q, credit_d;
   logic [15:0] timer_q, timer_d;
   logic        coin_reject_q, coin_reject_d;
   logic        fault_q, fault_d;

   logic [8:0]  sum;
   logic [9:0]  credit_w;
   logic        fits;
   logic [7:0]  acc;
   logic [1:0]  pick_code;
   logic [7:0]  pick_val;

   vend_change_pick u_pick (
      .credit     (credit_q),
      .coin_code  (pick_code),
      .coin_value (pick_val)
   );

   assign sum      = coin_sum(nickel, dime, quarter);
   assign credit_w = {2'b00, credit_q};

   // Next-state, credit, timer and one-cycle pulse computation.
   always_comb begin
      state_d       = state_q;
      credit_d      = credit_q;
      timer_d       = 16'd0;
      coin_reject_d = 1'b0;
      fault_d       = 1'b0;
      fits          = (credit_w + {1'b0, sum}) <= MAX_W;
      acc           = fits ? 8'(credit_w + {1'b0, sum}) : credit_q;
      case (state_q)
         ST_IDLE: begin
            // All-or-nothing coin acceptance against the ceiling.
            coin_reject_d = (sum != 9'd0) && !fits;
            credit_d      = acc;
            if (cancel) begin
               if (credit_q != 8'd0) state_d = ST_CHANGE;
            end else if (vend_req && (credit_w >= PRICE_W)) begin
               // Price check uses the registered credit, before this cycle's coins.
               credit_d = 8'({2'b00, acc} - PRICE_W);
               state_d  = ST_DISPENSE;
            end
         end
         ST_DISPENSE: begin
            coin_reject_d = (sum != 9'd0);
            if (dispense_ack) begin
               state_d = (credit_q != 8'd0) ? ST_CHANGE : ST_IDLE;
            end else if (timer_q == TMO_LAST) begin
               // Mechanism never confirmed: give the price back as change.
               credit_d = 8'(credit_w + PRICE_W);
               fault_d  = 1'b1;
               state_d  = ST_CHANGE;
            end else begin
               timer_d = timer_q + 16'd1;
            end
         end
         ST_CHANGE: begin
            coin_reject_d = (sum != 9'd0);
            if (credit_q == 8'd0) begin
               state_d = ST_IDLE;
            end else if (ret_ready) begin
               credit_d = credit_q - pick_val;
               if (credit_q == pick_val) state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // All controller state; reset loses any credit held.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         credit_q      <= 8'd0;
         timer_q       <= 16'd0;
         coin_reject_q <= 1'b0;
         fault_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         credit_q      <= credit_d;
         timer_q       <= timer_d;
         coin_reject_q <= coin_reject_d;
         fault_q       <= fault_d;
      end
   end

   assign dispense    = (state_q == ST_DISPENSE);
   assign ret_valid   = (state_q == ST_CHANGE);
   assign ret_coin    = ret_valid ? pick_code : COIN_NONE;
   assign busy        = (state_q != ST_IDLE);
   assign credit      = credit_q;
   assign coin_reject = coin_reject_q;
   assign fault       = fault_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// tb_vend_ctrl: vector table, directed corner sequences and random traffic against a reference model.
// Latency: inputs set #1 after posedge, outputs compared #1 after the following posedge.
// Backpressure: ret_ready and dispense_ack are driven by the stimulus itself.
module tb_vend_ctrl;

   localparam int PRICE = 100;
   localparam int MAX   = 200;
   localparam int TMO   = 20;

   localparam logic [6:0] N = 7'd1, D = 7'd2, Q = 7'd4, V = 7'd8, C = 7'd16, A = 7'd32, R = 7'd64;

   localparam int M_IDLE = 0, M_DISP = 1, M_RET = 2;

   logic       clk, reset_n;
   logic       nickel, dime, quarter, vend_req, cancel, dispense_ack, ret_ready;
   logic       dispense, ret_valid, coin_reject, fault, busy;
   logic [1:0] ret_coin;
   logic [7:0] credit;

   int checks = 0;
   int errors = 0;

   vend_ctrl #(.PRICE(PRICE), .MAX_CREDIT(MAX), .ACK_TIMEOUT(TMO)) dut (
      .clk(clk), .reset_n(reset_n),
      .nickel(nickel), .dime(dime), .quarter(quarter),
      .vend_req(vend_req), .cancel(cancel),
      .dispense(dispense), .dispense_ack(dispense_ack),
      .ret_valid(ret_valid), .ret_coin(ret_coin), .ret_ready(ret_ready),
      .credit(credit), .coin_reject(coin_reject), .fault(fault), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model (cents and a mode number) ----------------
   int m_credit, m_mode, m_wait;
   int m_rej, m_fault;

   function automatic int greedy(int c);
      return (c >= 25) ? 25 : ((c >= 10) ? 10 : 5);
   endfunction

   function automatic int code_of(int v);
      return (v == 25) ? 3 : ((v == 10) ? 2 : 1);
   endfunction

   task automatic m_reset();
      m_credit = 0; m_mode = M_IDLE; m_wait = 0; m_rej = 0; m_fault = 0;
   endtask

   task automatic m_step();
      int s;
      s = (nickel ? 5 : 0) + (dime ? 10 : 0) + (quarter ? 25 : 0);
      m_rej = 0;
      m_fault = 0;
      case (m_mode)
         M_IDLE: begin
            if (s > 0 && m_credit + s > MAX) begin
               m_rej = 1;
               s = 0;
            end
            if (cancel) begin
               if (m_credit > 0) m_mode = M_RET;
            end else if (vend_req && m_credit >= PRICE) begin
               m_mode = M_DISP;
               m_wait = 0;
               m_credit -= PRICE;
            end
            m_credit += s;
         end
         M_DISP: begin
            m_rej = (s > 0);
            if (dispense_ack) begin
               m_mode = (m_credit > 0) ? M_RET : M_IDLE;
            end else begin
               m_wait++;
               if (m_wait == TMO) begin
                  m_credit += PRICE;
                  m_fault = 1;
                  m_mode = M_RET;
               end
            end
         end
         default: begin
            m_rej = (s > 0);
            if (ret_ready) begin
               m_credit -= greedy(m_credit);
               if (m_credit == 0) m_mode = M_IDLE;
            end
         end
      endcase
   endtask

   // ---------------- helpers ----------------
   task automatic chk(string name, logic [31:0] act, int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_all(string tag, int cr, int dp, int rv, int cn, int rj, int ft);
      chk({tag, ".credit"}, credit, cr);
      chk({tag, ".dispense"}, dispense, dp);
      chk({tag, ".ret_valid"}, ret_valid, rv);
      chk({tag, ".ret_coin"}, ret_coin, cn);
      chk({tag, ".coin_reject"}, coin_reject, rj);
      chk({tag, ".fault"}, fault, ft);
      chk({tag, ".busy"}, busy, (dp != 0 || rv != 0) ? 1 : 0);
   endtask

   task automatic apply(logic [6:0] m);
      nickel = m[0]; dime = m[1]; quarter = m[2]; vend_req = m[3];
      cancel = m[4]; dispense_ack = m[5]; ret_ready = m[6];
   endtask

   task automatic tick();
      m_step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(string tag);
      apply(7'd0);
      reset_n = 1'b0;
      m_reset();
      #1;
      check_all(tag, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [6:0] ins;
      int credit;
      int disp;
      int rv;
      int coin;
      int rej;
   } vec_t;

   vec_t tbl[$];

   task automatic add(logic [6:0] ins, int cr, int dp, int rv, int cn, int rj);
      vec_t v;
      v.ins = ins; v.credit = cr; v.disp = dp; v.rv = rv; v.coin = cn; v.rej = rj;
      tbl.push_back(v);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      int cnt, nq;
      int exp_coin[4];
      int exp_cred[4];
      exp_coin = '{3, 3, 2, 1};
      exp_cred = '{40, 15, 5, 0};

      reset_n = 1'b1;
      apply(7'd0);
      m_reset();
      #2;
      do_reset("reset");

      // four quarters, vend, ack with no change
      add(Q, 25, 0, 0, 0, 0);      add(Q, 50, 0, 0, 0, 0);
      add(Q, 75, 0, 0, 0, 0);      add(Q, 100, 0, 0, 0, 0);
      add(V, 0, 1, 0, 0, 0);       add(0, 0, 1, 0, 0, 0);
      add(A, 0, 0, 0, 0, 0);       add(0, 0, 0, 0, 0, 0);
      // 105 cents, vend, one nickel of change
      add(Q|D, 35, 0, 0, 0, 0);    add(Q|D, 70, 0, 0, 0, 0);
      add(Q|D, 105, 0, 0, 0, 0);   add(V, 5, 1, 0, 0, 0);
      add(A, 5, 0, 1, 1, 0);       add(R, 0, 0, 0, 0, 0);
      // ceiling: 195 + quarter rejected, + nickel accepted
      add(N|D|Q, 40, 0, 0, 0, 0);  add(N|D|Q, 80, 0, 0, 0, 0);
      add(N|D|Q, 120, 0, 0, 0, 0); add(N|D|Q, 160, 0, 0, 0, 0);
      add(Q|D, 195, 0, 0, 0, 0);   add(Q, 195, 0, 0, 0, 1);
      add(N, 200, 0, 0, 0, 0);
      // coin during dispense rejected, then four quarters of change
      add(V, 100, 1, 0, 0, 0);     add(Q, 100, 1, 0, 0, 1);
      add(A, 100, 0, 1, 3, 0);     add(R, 75, 0, 1, 3, 0);
      add(R, 50, 0, 1, 3, 0);      add(R, 25, 0, 1, 3, 0);
      add(R, 0, 0, 0, 0, 0);
      // ignored requests, cancel beats vend
      add(C, 0, 0, 0, 0, 0);       add(N, 5, 0, 0, 0, 0);
      add(V, 5, 0, 0, 0, 0);       add(A, 5, 0, 0, 0, 0);
      add(V|C, 5, 0, 1, 1, 0);     add(R, 0, 0, 0, 0, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i].ins);
         tick();
         check_all($sformatf("vec%0d", i), tbl[i].credit, tbl[i].disp, tbl[i].rv, tbl[i].coin, tbl[i].rej, 0);
      end

      // 65 cents, cancel; ready held low 3 cycles, then Q,Q,D,N back to back
      do_reset("rst_a");
      apply(Q|D); tick();
      apply(Q|N); tick();
      chk("a.credit65", credit, 65);
      apply(C); tick();
      apply(7'd0);
      for (int i = 0; i < 3; i++) begin
         chk("a.hold_coin", ret_coin, 3);
         chk("a.hold_credit", credit, 65);
         tick();
      end
      chk("a.hold_valid", ret_valid, 1);
      apply(R);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("a.coin%0d", i), ret_coin, exp_coin[i]);
         tick();
         chk($sformatf("a.credit%0d", i), credit, exp_cred[i]);
      end
      chk("a.idle", busy, 0);

      // 100 cents, vend, never acknowledged
      do_reset("rst_b");
      for (int i = 0; i < 4; i++) begin apply(Q); tick(); end
      apply(V); tick();
      apply(7'd0);
      cnt = 0;
      while (dispense === 1'b1 && cnt < TMO + 5) begin
         cnt++;
         tick();
      end
      chk("b.dispense_cycles", cnt, TMO);
      chk("b.fault", fault, 1);
      chk("b.dispense_low", dispense, 0);
      chk("b.refund", credit, 100);
      chk("b.change", ret_valid, 1);
      tick();
      chk("b.fault_pulse", fault, 0);
      apply(R);
      nq = 0; cnt = 0;
      while (ret_valid === 1'b1 && cnt < 10) begin
         if (ret_coin == 2'd3) nq++;
         cnt++;
         tick();
      end
      chk("b.quarters", nq, 4);
      chk("b.final_credit", credit, 0);

      // 150 cents, vend+cancel together, six quarters, then reset mid-change
      do_reset("rst_c");
      for (int i = 0; i < 3; i++) begin apply(N|D|Q); tick(); end
      apply(Q|N); tick();
      apply(V|C); tick();
      chk("c.no_dispense", dispense, 0);
      chk("c.change", ret_valid, 1);
      apply(R);
      nq = 0; cnt = 0;
      while (ret_valid === 1'b1 && cnt < 12) begin
         if (ret_coin == 2'd3) nq++;
         cnt++;
         tick();
      end
      chk("c.quarters", nq, 6);
      apply(Q); tick();
      apply(C); tick();
      apply(7'd0);
      chk("c.mid_change", ret_valid, 1);
      do_reset("c.reset_mid");
      apply(Q); tick();
      chk("c.first_after_reset", credit, 25);

      // random traffic against the model
      do_reset("rst_rnd");
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 499) == 0) begin
            do_reset("rnd_reset");
         end else begin
            nickel       = ($urandom_range(0, 3) == 0);
            dime         = ($urandom_range(0, 3) == 0);
            quarter      = ($urandom_range(0, 3) == 0);
            vend_req     = ($urandom_range(0, 3) == 0);
            cancel       = ($urandom_range(0, 15) == 0);
            dispense_ack = ($urandom_range(0, 7) == 0);
            ret_ready    = ($urandom_range(0, 1) == 0);
            tick();
            check_all("rnd", m_credit, (m_mode == M_DISP) ? 1 : 0, (m_mode == M_RET) ? 1 : 0,
                      (m_mode == M_RET) ? code_of(greedy(m_credit)) : 0, m_rej, m_fault);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vend_ctrl.md
VEND_CTRL -- requirements
Module: vend_ctrl

Interface
REQ-001 Parameter PRICE, default 100: item price in cents; SHALL be a multiple of 5 and <= MAX_CREDIT.
REQ-002 Parameter MAX_CREDIT, default 200: credit ceiling in cents; SHALL be a multiple of 5 and <= 215.
REQ-003 Parameter ACK_TIMEOUT, default 1000: cycles to wait for dispense_ack; range 1..65535.
REQ-004 clk  input  1  clock; all state changes on posedge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 nickel, dime, quarter  input  1 each  coin-accepted pulses, synchronous to clk; any combination may be high in one cycle.
REQ-007 vend_req  input  1  purchase request, sampled each cycle.
REQ-008 cancel  input  1  refund request, sampled each cycle.
REQ-009 dispense  output  1  dispense command, held until acknowledged.
REQ-010 dispense_ack  input  1  mechanism has dispensed.
REQ-011 ret_valid  output  1  a change coin is offered.
REQ-012 ret_coin  output  2  offered coin: 0 none, 1 nickel, 2 dime, 3 quarter.
REQ-013 ret_ready  input  1  coin payout mechanism accepts the offered coin.
REQ-014 credit  output  8  current credit in cents, registered.
REQ-015 coin_reject  output  1  one-cycle pulse: coins presented in the previous cycle were not accepted.
REQ-016 fault  output  1  one-cycle pulse: dispense timeout occurred.
REQ-017 busy  output  1  high whenever state is not IDLE.

Function
REQ-018 FSM states: IDLE, DISPENSE, CHANGE; dispense = (state==DISPENSE); ret_valid = (state==CHANGE); all outputs registered or decoded from registered state/credit only.
REQ-019 Coin sum per cycle = 5*nickel + 10*dime + 25*quarter (0..40); sum computed at >= 9 bits before comparison.
REQ-020 IDLE, sum>0: if credit+sum <= MAX_CREDIT, the whole sum is added; otherwise all coins of that cycle are rejected (no partial acceptance) and coin_reject pulses next cycle.
REQ-021 Coins presented in DISPENSE or CHANGE are rejected: credit unchanged, coin_reject pulses next cycle.
REQ-022 IDLE, cancel=1 and credit>0 -> CHANGE; cancel with credit==0 is ignored.
REQ-023 IDLE, vend_req=1, cancel=0, credit>=PRICE (registered value, before this cycle's coins) -> DISPENSE; next credit = credit - PRICE + accepted sum; dispense high from the next cycle.
REQ-024 IDLE, vend_req with credit<PRICE is ignored; state unchanged.
REQ-025 vend_req and cancel in the same cycle: cancel wins.
REQ-026 DISPENSE: 16-bit timer clears on entry and increments each cycle; dispense_ack=1 -> CHANGE if credit>0, else IDLE.
REQ-027 DISPENSE: if timer reaches ACK_TIMEOUT-1 without ack, then credit += PRICE (refund), fault pulses for one cycle, state -> CHANGE; ack in the same cycle takes priority over timeout.
REQ-028 CHANGE: ret_coin is chosen greedily from the registered credit: quarter if credit>=25, else dime if >=10, else nickel.
REQ-029 CHANGE: on ret_valid && ret_ready, credit decreases by the offered coin value; when the new credit is 0, state -> IDLE; ret_valid SHALL stay asserted and ret_coin stable while ret_ready is low.
REQ-030 credit SHALL always be a multiple of 5 and never exceed MAX_CREDIT, except transiently by at most PRICE after a timeout refund; it never wraps.
REQ-031 dispense_ack outside DISPENSE and ret_ready outside CHANGE are ignored.

Reset
REQ-032 Asserting reset_n low at any time, including mid-dispense or mid-change, SHALL immediately force state=IDLE, credit=0, timer=0, and dispense, ret_valid, ret_coin, coin_reject, fault and busy all to 0; credit is lost.
REQ-033 The first posedge after reset_n deasserts SHALL sample coins normally.

Structure
REQ-034 Package vend_pkg SHALL hold the state enum, the coin code enum (COIN_NONE/NICKEL/DIME/QUARTER), and the coin value constants 5/10/25.
REQ-035 The greedy coin selection SHALL be a combinational sub-module vend_change_pick (input credit, output coin code and value).

Verification
REQ-036 4 quarters, then vend_req -> dispense=1 on the next cycle, credit=0; ack -> IDLE, ret_valid never asserts.
REQ-037 3 quarters + 3 dimes (credit 105), vend_req, ack -> CHANGE offers one nickel; ret_ready=1 -> credit 0, IDLE.
REQ-038 credit 195, quarter -> coin_reject on the next cycle, credit stays 195; nickel -> credit 200.
REQ-039 credit 65, cancel, ret_ready=1 continuously -> coins Q,Q,D,N on 4 consecutive cycles, then IDLE; ret_ready held low 3 cycles -> Q held stable.
REQ-040 credit 100, vend_req, no ack for ACK_TIMEOUT cycles -> fault pulse, dispense low, credit 100, then 4 quarters returned.
REQ-041 credit 150, vend_req+cancel same cycle -> no dispense, 6 quarters returned; reset asserted mid-change -> all outputs 0 immediately.
